vc_credit_sender: RTL and testbench

VC_CREDIT_SENDER -- requirements
Module: vc_credit_sender

---
 rtl/vc_credit_sender_if.sv | 30 +++
 rtl/vc_credit_sender.sv | 112 +++++++++++
 tb/tb_vc_credit_sender.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vc_credit_sender_if.sv
// Producer/remote-queue bundle for the credit-based virtual-channel sender.
// master: producer plus remote-queue environment; slave: the sender itself.
interface vc_credit_sender_if #(
    parameter int p_msg_nbits   = 8,
    parameter int p_num_credits = 2
);
    localparam int c_cnt_nbits = $clog2(p_num_credits + 1);

    logic                   domain;
    logic                   cur_domain;
    logic                   enq_val;
    logic                   enq_rdy;
    logic [p_msg_nbits-1:0] enq_msg;
    logic                   send_val;
    logic [p_msg_nbits-1:0] send_msg;
    logic                   credit_return;
    logic [c_cnt_nbits-1:0] credits;
    logic                   draining;
    logic                   err;

    modport master (
        output domain, enq_val, enq_msg, credit_return,
        input  cur_domain, enq_rdy, send_val, send_msg, credits, draining, err
    );

    modport slave (
        input  domain, enq_val, enq_msg, credit_return,
        output cur_domain, enq_rdy, send_val, send_msg, credits, draining, err
    );
endinterface

// File: rtl/vc_credit_sender.sv
// Credit-based sender feeding a remote queue of depth p_num_credits.
// The channel belongs to one security domain at a time; a domain change
// drains every in-flight message (all credits back) before ownership moves.
module vc_credit_sender #(
    parameter int p_msg_nbits   = 8,
    parameter int p_num_credits = 2
) (
    input  logic               clk,
    input  logic               reset,
    vc_credit_sender_if.slave  bus
);
    localparam int c_cnt_nbits = $clog2(p_num_credits + 1);
    localparam logic [c_cnt_nbits-1:0] c_full = c_cnt_nbits'(p_num_credits);
    localparam logic [c_cnt_nbits-1:0] c_one  = c_cnt_nbits'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_cnt_nbits-1:0] r_credits;
    logic [c_cnt_nbits-1:0] w_credits_next;
    logic                   r_err;
    logic                   w_err_next;
    logic                   r_cur_domain;
    logic                   w_cur_domain_next;
    logic                   r_send_val;
    logic [p_msg_nbits-1:0] r_send_msg;
    logic                   w_enq_rdy;
    logic                   w_do_enq;

    // Ready depends only on state, credits and domain match, never on enq_val,
    // so a domain mismatch blocks traffic in the very cycle it appears.
    assign w_enq_rdy = (r_state == ST_RUN) && (r_credits != '0) &&
                       (bus.domain == r_cur_domain);
    assign w_do_enq  = bus.enq_val && w_enq_rdy;

    // Next-state logic: RUN -> DRAIN on mismatch, DRAIN -> SWITCH once the
    // remote queue is empty and nothing is on the wire, SWITCH lasts one cycle.
    always_comb begin
        w_state_next      = r_state;
        w_cur_domain_next = r_cur_domain;
        case (r_state)
            ST_RUN: begin
                if (bus.domain != r_cur_domain) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A domain that flips back meanwhile does not cancel the drain.
                if ((r_credits == c_full) && !r_send_val) begin
                    w_state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_cur_domain_next = bus.domain;
                w_state_next      = ST_RUN;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // Credit arithmetic: simultaneous accept and return cancel out; a return
    // with the counter already full saturates and raises the sticky error.
    always_comb begin
        w_credits_next = r_credits;
        w_err_next     = r_err;
        if (w_do_enq && !bus.credit_return) begin
            w_credits_next = r_credits - c_one;
        end else if (!w_do_enq && bus.credit_return) begin
            if (r_credits == c_full) begin
                w_err_next = 1'b1;
            end else begin
                w_credits_next = r_credits + c_one;
            end
        end
    end

    // State, counters and the registered send port; reset discards any
    // pending switch and in-flight accounting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_credits    <= c_full;
            r_err        <= 1'b0;
            r_cur_domain <= 1'b0;
            r_send_val   <= 1'b0;
            r_send_msg   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_credits    <= w_credits_next;
            r_err        <= w_err_next;
            r_cur_domain <= w_cur_domain_next;
            r_send_val   <= w_do_enq;
            // Message bus is zeroed whenever no send is presented.
            r_send_msg   <= w_do_enq ? bus.enq_msg : '0;
        end
    end

    assign bus.enq_rdy    = w_enq_rdy;
    assign bus.cur_domain = r_cur_domain;
    assign bus.send_val   = r_send_val;
    assign bus.send_msg   = r_send_msg;
    assign bus.credits    = r_credits;
    assign bus.draining   = (r_state == ST_DRAIN) || (r_state == ST_SWITCH);
    assign bus.err        = r_err;
endmodule

// File: tb/tb_vc_credit_sender.sv
// Scenario bench for vc_credit_sender: directed cases followed by a random run
// checked against a transaction-level model of credits and channel ownership.
module tb_vc_credit_sender;
    localparam int N = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    vc_credit_sender_if #(.p_msg_nbits(8), .p_num_credits(N)) bus ();

    vc_credit_sender #(.p_msg_nbits(8), .p_num_credits(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: ownership phase, credit count, sticky error, send port.
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_SWITCH = 2;
    int       m_phase   = PH_RUN;
    int       m_credits = N;
    bit       m_err     = 0;
    bit       m_cur     = 0;
    bit       m_sval    = 0;
    bit [7:0] m_smsg    = 0;

    function automatic bit model_rdy();
        return (m_phase == PH_RUN) && (m_credits > 0) && (bus.domain == m_cur);
    endfunction

    // One clock: evaluate the model on pre-edge inputs, then commit after the edge.
    task automatic step();
        int       n_phase, n_credits;
        bit       n_err, n_cur, n_sval, acc;
        bit [7:0] n_smsg;
        if (!reset) begin
            n_phase = PH_RUN; n_credits = N; n_err = 0; n_cur = 0;
            n_sval = 0; n_smsg = 0;
        end else begin
            acc       = bus.enq_val && model_rdy();
            n_sval    = acc;
            n_smsg    = acc ? bus.enq_msg : 8'h00;
            n_credits = m_credits - int'(acc) + int'(bus.credit_return);
            n_err     = m_err;
            if (n_credits > N) begin
                n_credits = N;
                n_err     = 1;
            end
            n_phase = m_phase;
            n_cur   = m_cur;
            if (m_phase == PH_RUN && bus.domain != m_cur) n_phase = PH_DRAIN;
            else if (m_phase == PH_DRAIN && m_credits == N && !m_sval) n_phase = PH_SWITCH;
            else if (m_phase == PH_SWITCH) begin
                n_cur   = bus.domain;
                n_phase = PH_RUN;
            end
            if (acc) $display("txn: enq msg=%02h domain=%0d", bus.enq_msg, bus.domain);
        end
        @(posedge clk);
        #1;
        m_phase = n_phase; m_credits = n_credits; m_err = n_err; m_cur = n_cur;
        m_sval = n_sval; m_smsg = n_smsg;
    endtask

    task automatic drive(input bit v, input bit [7:0] msg, input bit cr);
        bus.enq_val       = v;
        bus.enq_msg       = msg;
        bus.credit_return = cr;
    endtask

    task automatic test_reset();
        reset = 0;
        bus.domain = 0;
        drive(1, 8'h55, 1);
        step(); step();
        reset = 1;
        drive(0, 8'h00, 0);
        #1;
        checks++; if (bus.credits !== 2'd2) begin failures++; $display("FAIL reset_credits got=%0d exp=2", bus.credits); end
        checks++; if (bus.send_val !== 1'b0 || bus.send_msg !== 8'h00) begin failures++; $display("FAIL reset_send got=%0d/%02h exp=0/00", bus.send_val, bus.send_msg); end
        checks++; if (bus.err !== 1'b0 || bus.draining !== 1'b0 || bus.cur_domain !== 1'b0) begin failures++; $display("FAIL reset_flags got err=%0d drn=%0d cur=%0d exp=0/0/0", bus.err, bus.draining, bus.cur_domain); end
        checks++; if (bus.enq_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%0d exp=1", bus.enq_rdy); end
    endtask

    task automatic test_back_to_back();
        drive(1, 8'hA1, 0); #1;
        checks++; if (bus.enq_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy_a1 got=%0d exp=1", bus.enq_rdy); end
        step();
        checks++; if (bus.send_val !== 1'b1 || bus.send_msg !== 8'hA1 || bus.credits !== 2'd1) begin failures++; $display("FAIL b2b_a1 got=%0d/%02h/%0d exp=1/a1/1", bus.send_val, bus.send_msg, bus.credits); end
        drive(1, 8'hA2, 0); step();
        checks++; if (bus.send_val !== 1'b1 || bus.send_msg !== 8'hA2 || bus.credits !== 2'd0) begin failures++; $display("FAIL b2b_a2 got=%0d/%02h/%0d exp=1/a2/0", bus.send_val, bus.send_msg, bus.credits); end
        drive(1, 8'hA3, 0); #1;
        checks++; if (bus.enq_rdy !== 1'b0) begin failures++; $display("FAIL b2b_rdy_empty got=%0d exp=0", bus.enq_rdy); end
        step();
        checks++; if (bus.send_val !== 1'b0 || bus.send_msg !== 8'h00) begin failures++; $display("FAIL b2b_idle got=%0d/%02h exp=0/00", bus.send_val, bus.send_msg); end
        drive(1, 8'hA3, 1); step();
        checks++; if (bus.credits !== 2'd1) begin failures++; $display("FAIL b2b_return got=%0d exp=1", bus.credits); end
        drive(1, 8'hA3, 0); step();
        checks++; if (bus.send_val !== 1'b1 || bus.send_msg !== 8'hA3 || bus.credits !== 2'd0) begin failures++; $display("FAIL b2b_a3 got=%0d/%02h/%0d exp=1/a3/0", bus.send_val, bus.send_msg, bus.credits); end
        drive(0, 8'h00, 1); step(); step();
        drive(0, 8'h00, 0);
        checks++; if (bus.credits !== 2'd2) begin failures++; $display("FAIL b2b_refill got=%0d exp=2", bus.credits); end
    endtask

    task automatic test_simultaneous();
        drive(1, 8'hB0, 0); step();
        drive(1, 8'hB1, 1); #1;
        checks++; if (bus.enq_rdy !== 1'b1) begin failures++; $display("FAIL sim_rdy got=%0d exp=1", bus.enq_rdy); end
        step();
        checks++; if (bus.credits !== 2'd1 || bus.send_val !== 1'b1 || bus.send_msg !== 8'hB1) begin failures++; $display("FAIL sim_both got=%0d/%0d/%02h exp=1/1/b1", bus.credits, bus.send_val, bus.send_msg); end
        drive(0, 8'h00, 1); step();
        drive(0, 8'h00, 0);
        checks++; if (bus.credits !== 2'd2 || bus.send_msg !== 8'h00) begin failures++; $display("FAIL sim_refill got=%0d/%02h exp=2/00", bus.credits, bus.send_msg); end
    endtask

    task automatic test_domain_switch();
        drive(1, 8'hC1, 0); step();
        drive(1, 8'hC2, 0); step();
        drive(0, 8'h00, 0); bus.domain = 1; #1;
        checks++; if (bus.enq_rdy !== 1'b0) begin failures++; $display("FAIL sw_rdy_detect got=%0d exp=0", bus.enq_rdy); end
        step();
        checks++; if (bus.draining !== 1'b1 || bus.enq_rdy !== 1'b0 || bus.cur_domain !== 1'b0) begin failures++; $display("FAIL sw_drain got drn=%0d rdy=%0d cur=%0d exp=1/0/0", bus.draining, bus.enq_rdy, bus.cur_domain); end
        bus.domain = 0; step();
        checks++; if (bus.draining !== 1'b1) begin failures++; $display("FAIL sw_no_abort got=%0d exp=1", bus.draining); end
        bus.domain = 1; drive(0, 8'h00, 1); step(); step();
        checks++; if (bus.credits !== 2'd2 || bus.draining !== 1'b1) begin failures++; $display("FAIL sw_credits_back got=%0d/%0d exp=2/1", bus.credits, bus.draining); end
        drive(0, 8'h00, 0); step();
        checks++; if (bus.draining !== 1'b1 || bus.cur_domain !== 1'b0) begin failures++; $display("FAIL sw_switch got drn=%0d cur=%0d exp=1/0", bus.draining, bus.cur_domain); end
        step();
        checks++; if (bus.draining !== 1'b0 || bus.cur_domain !== 1'b1 || bus.enq_rdy !== 1'b1) begin failures++; $display("FAIL sw_run got drn=%0d cur=%0d rdy=%0d exp=0/1/1", bus.draining, bus.cur_domain, bus.enq_rdy); end
        drive(1, 8'hC3, 0); bus.domain = 0; #1;
        checks++; if (bus.enq_rdy !== 1'b0) begin failures++; $display("FAIL sw_back_rdy got=%0d exp=0", bus.enq_rdy); end
        step();
        checks++; if (bus.draining !== 1'b1 || bus.send_val !== 1'b0) begin failures++; $display("FAIL sw_back_drain got=%0d/%0d exp=1/0", bus.draining, bus.send_val); end
        drive(0, 8'h00, 0); step(); step();
        checks++; if (bus.draining !== 1'b0 || bus.cur_domain !== 1'b0) begin failures++; $display("FAIL sw_back_run got=%0d/%0d exp=0/0", bus.draining, bus.cur_domain); end
    endtask

    task automatic test_overflow();
        drive(0, 8'h00, 1); step();
        checks++; if (bus.credits !== 2'd2 || bus.err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d/%0d exp=2/1", bus.credits, bus.err); end
        drive(1, 8'hD1, 0); step();
        drive(0, 8'h00, 1); step();
        drive(0, 8'h00, 0);
        checks++; if (bus.err !== 1'b1 || bus.credits !== 2'd2) begin failures++; $display("FAIL ovf_sticky got=%0d/%0d exp=1/2", bus.err, bus.credits); end
    endtask

    task automatic test_reset_in_drain();
        drive(1, 8'hE1, 0); step();
        drive(0, 8'h00, 0); bus.domain = 1; step();
        checks++; if (bus.draining !== 1'b1) begin failures++; $display("FAIL rst_pre_drain got=%0d exp=1", bus.draining); end
        reset = 0; drive(1, 8'hE2, 1); step();
        checks++; if (bus.credits !== 2'd2 || bus.draining !== 1'b0 || bus.cur_domain !== 1'b0) begin failures++; $display("FAIL rst_drain_state got=%0d/%0d/%0d exp=2/0/0", bus.credits, bus.draining, bus.cur_domain); end
        checks++; if (bus.send_val !== 1'b0 || bus.send_msg !== 8'h00 || bus.err !== 1'b0) begin failures++; $display("FAIL rst_drain_out got=%0d/%02h/%0d exp=0/00/0", bus.send_val, bus.send_msg, bus.err); end
        reset = 1; drive(0, 8'h00, 0); bus.domain = 0; step();
        checks++; if (bus.draining !== 1'b0 || bus.enq_rdy !== 1'b1) begin failures++; $display("FAIL rst_run got=%0d/%0d exp=0/1", bus.draining, bus.enq_rdy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 19) == 0) bus.domain = ~bus.domain;
            drive($urandom_range(0, 2) != 0, 8'($urandom),
                  ((N - m_credits) > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 99) == 0));
            #1;
            checks++; if (bus.enq_rdy !== model_rdy()) begin failures++; $display("FAIL rnd_rdy cyc=%0d got=%0d exp=%0d", i, bus.enq_rdy, model_rdy()); end
            step();
            checks++; if (bus.send_val !== m_sval || bus.send_msg !== m_smsg) begin failures++; $display("FAIL rnd_send cyc=%0d got=%0d/%02h exp=%0d/%02h", i, bus.send_val, bus.send_msg, m_sval, m_smsg); end
            checks++; if (int'(bus.credits) != m_credits || bus.err !== m_err) begin failures++; $display("FAIL rnd_credits cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.credits, bus.err, m_credits, m_err); end
            checks++; if (bus.draining !== (m_phase != PH_RUN) || bus.cur_domain !== m_cur) begin failures++; $display("FAIL rnd_domain cyc=%0d got=%0d/%0d exp=%0d/%0d", i, bus.draining, bus.cur_domain, m_phase != PH_RUN, m_cur); end
            checks++; if (!bus.send_val && bus.send_msg !== 8'h00) begin failures++; $display("FAIL rnd_msg_zero cyc=%0d got=%02h exp=00", i, bus.send_msg); end
        end
    endtask

    initial begin
        bus.domain = 0;
        drive(0, 8'h00, 0);
        test_reset();
        test_back_to_back();
        test_simultaneous();
        test_domain_switch();
        test_overflow();
        test_reset_in_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
